led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern generator for the board demo path. It replaces the fixed 8-bit single-rotation LED block. It adds configurable width and step rate, six pattern modes, direction, pause, seed load, output masking and 16-level PWM brightness. It sits between the switch/config inputs and any LED bank, and exports step and wrap strobes for other display blocks.

## Interface
- WIDTH, 8, pattern/LED width; legal values 8, 16, 32
- DIV_W, 24, width of step divider input
- clk  in  1  system clock (100 kHz on board)
- rstn  in  1  reset, asynchronous, active-low
- step_div  in  DIV_W  clocks per pattern step; 0 treated as 1
- mode  in  3  0 rotate, 1 bounce, 2 counter, 3 bar, 4 LFSR, 5 static seed, 6/7 off
- dir  in  1  0 = left/up, 1 = right/down (rotate, counter)
- pause  in  1  freeze prescaler and pattern
- load  in  1  synchronous pattern load from seed
- seed  in  WIDTH  load value
- mask  in  WIDTH  per-bit output enable
- bright  in  4  PWM duty; 0 off, 1..14 = n/16, 15 = fully on
- led_out  out  WIDTH  registered LED drive
- step_pulse  out  1  one-cycle strobe per pattern step
- wrap_pulse  out  1  one-cycle strobe when a pattern sequence completes

## Operation
- Reset: pattern 0, prescaler 0, pwm_cnt 0, mode_q 7, bounce/bar state UP/FILL, led_out 0, step_pulse 0, wrap_pulse 0.
- Prescaler cnt counts 0..max(step_div,1)-1 while pause=0. Step occurs on the clock where cnt is at terminal value. cnt returns to 0.
- Mode change (mode != mode_q) has highest priority. mode_q <= mode, pattern <= init(mode), cnt <= 0, bounce/bar state reset, no step that cycle.
- load=1 has next priority: pattern <= seed (LFSR: 0 becomes 1), cnt <= 0, no step.
- Init values: rotate 1, bounce 1, counter 0, bar 0, LFSR 1, static seed, off 0.
- Step actions:
  - Rotate: dir=0 gives {p[W-2:0],p[W-1]}; dir=1 gives {p[0],p[W-1:1]}. Zero pattern stays zero.
  - Bounce: single one-hot bit, FSM UP/DOWN. UP shifts left. On reaching bit W-1 it switches to DOWN. DOWN shifts right. On reaching bit 0 it switches to UP. Ends stay lit for one step each, with no double dwell.
  - Counter: p ± 1 (dir), modulo 2^WIDTH.
  - Bar: FSM FILL/DRAIN. FILL gives p <= {p[W-2:0],1'b1}. On all-ones it switches to DRAIN. DRAIN gives p <= p >> 1. On 0 it switches to FILL.
  - LFSR: Galois right shift. If p[0], XOR taps 0xB8 (8), 0xB400 (16), 0x80200003 (32).
  - Static and off: no change.
- wrap_pulse fires on a step whose new pattern equals init(mode) for rotate, bounce, counter, LFSR. For bar it fires on the DRAIN to FILL transition. It never fires in static or off.
- PWM: pwm_cnt is a free-running 4-bit counter and is never paused. pwm_on = (bright==15) | (pwm_cnt < bright).
- led_out <= (mode_q>=6) ? 0 : pattern & mask & {WIDTH{pwm_on}}.

## Timing
- Step decision at edge N updates pattern at N. step_pulse is high during cycle N+1. led_out reflects the new pattern at N+1, so there is one cycle of latency.
- pause=1 holds cnt and pattern. step_pulse and wrap_pulse stay 0. led_out still tracks mask, bright and PWM.
- step_div changed mid-count: if cnt >= new terminal, a step is taken on the next clock.
- Simultaneous mode change + load: mode change wins and load is ignored that cycle.
- Simultaneous load + terminal count: load wins and no step_pulse is generated.
- Reset mid-operation clears everything asynchronously. After release the first cycle performs a mode reload unless mode=7.

## Test plan
- WIDTH=8, mode 0, dir 0, step_div 4, mask FF, bright 15 -> led_out 01,02,04,…,80,01 every 4 clocks; wrap_pulse with the 01 step; step_pulse period 4.
- Mode 1, step_div 1 -> 01,02,…,80,40,…,01; each end dwells exactly one step; wrap_pulse on return to 01 (period 14 steps).
- Mode 2, dir 1, load seed 00 -> FF,FE,…; wrap_pulse when the pattern reaches 00 after 256 steps. Mode 3 -> 00,01,03,…,FF,7F,…,00; wrap_pulse on the DRAIN to FILL transition.
- Mode 4, load seed 00 -> pattern forced to 01; sequence period 255 steps without hitting 00; wrap_pulse once per period.
- Mode 5 seed A5, mask 0F, bright 4 -> led_out 05 for 4 of 16 cycles, else 00. With bright 0, always 00. With pause=1, PWM still runs.
- Mode change 0 to 3 mid-count with load asserted together -> pattern 00, cnt 0, load ignored, no step_pulse that cycle. Assert rstn low mid-step -> all outputs 0 immediately.

Source files
------------

// File: rtl/led_pattern_engine_if.sv
// Configuration and LED-drive bundle for led_pattern_engine.
// The master side drives the pattern configuration. The slave side is the engine, which returns the LED drive and the strobes.
interface led_pattern_engine_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
);
    logic [DIV_W-1:0] step_div;
    logic [2:0]       mode;
    logic             dir;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] mask;
    logic [3:0]       bright;
    logic [WIDTH-1:0] led_out;
    logic             step_pulse;
    logic             wrap_pulse;

    modport master (
        output step_div, mode, dir, pause, load, seed, mask, bright,
        input  led_out, step_pulse, wrap_pulse
    );

    modport slave (
        input  step_div, mode, dir, pause, load, seed, mask, bright,
        output led_out, step_pulse, wrap_pulse
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern generator with prescaled stepping and six pattern modes.
// It also provides 16-level PWM brightness, per-bit masking and step/wrap strobes.
module led_pattern_engine #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    led_pattern_engine_if.slave  pif
);
    localparam logic [2:0] M_ROTATE  = 3'd0;
    localparam logic [2:0] M_BOUNCE  = 3'd1;
    localparam logic [2:0] M_COUNTER = 3'd2;
    localparam logic [2:0] M_BAR     = 3'd3;
    localparam logic [2:0] M_LFSR    = 3'd4;
    localparam logic [2:0] M_STATIC  = 3'd5;
    localparam logic [2:0] M_OFF     = 3'd7;

    localparam logic [WIDTH-1:0] P_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [31:0] TAPS_ALL = (WIDTH == 32) ? 32'h8020_0003 :
                                       (WIDTH == 16) ? 32'h0000_B400 : 32'h0000_00B8;
    localparam logic [WIDTH-1:0] LFSR_TAPS = TAPS_ALL[WIDTH-1:0];

    typedef enum logic {BNC_UP   = 1'b0, BNC_DOWN  = 1'b1} bnc_state_t;
    typedef enum logic {BAR_FILL = 1'b0, BAR_DRAIN = 1'b1} bar_state_t;

    logic [WIDTH-1:0] pattern_r, pattern_nxt_s;
    logic [DIV_W-1:0] cnt_r, cnt_nxt_s, div_eff_s, term_s;
    logic [3:0]       pwm_cnt_r;
    logic [2:0]       mode_q_r;
    bnc_state_t       bnc_st_r, bnc_nxt_s;
    bar_state_t       bar_st_r, bar_nxt_s;
    logic [WIDTH-1:0] led_out_r, led_nxt_s;
    logic             step_d_r, wrap_d_r, step_pulse_r, wrap_pulse_r;
    logic             mode_chg_s, at_term_s, step_s, wrap_s, pwm_on_s;

    function automatic logic [WIDTH-1:0] init_pattern(input logic [2:0] m,
                                                      input logic [WIDTH-1:0] s);
        case (m)
            M_ROTATE, M_BOUNCE, M_LFSR: init_pattern = P_ONE;
            M_STATIC:                   init_pattern = s;
            default:                    init_pattern = '0;
        endcase
    endfunction

    assign div_eff_s  = (pif.step_div == '0) ? CNT_ONE : pif.step_div;
    assign term_s     = div_eff_s - CNT_ONE;
    // >= rather than == so that lowering step_div below the current count steps at once
    assign at_term_s  = (cnt_r >= term_s);
    assign mode_chg_s = (pif.mode != mode_q_r);
    assign step_s     = !mode_chg_s && !pif.load && !pif.pause && at_term_s;

    // Next pattern, prescaler and bounce/bar state; priority: mode change, load, pause, step
    always_comb begin
        pattern_nxt_s = pattern_r;
        cnt_nxt_s     = cnt_r;
        bnc_nxt_s     = bnc_st_r;
        bar_nxt_s     = bar_st_r;
        wrap_s        = 1'b0;
        if (mode_chg_s) begin
            pattern_nxt_s = init_pattern(pif.mode, pif.seed);
            cnt_nxt_s     = '0;
            bnc_nxt_s     = BNC_UP;
            bar_nxt_s     = BAR_FILL;
        end else if (pif.load) begin
            pattern_nxt_s = ((mode_q_r == M_LFSR) && (pif.seed == '0)) ? P_ONE : pif.seed;
            cnt_nxt_s     = '0;
        end else if (pif.pause) begin
            cnt_nxt_s     = cnt_r;
        end else if (at_term_s) begin
            cnt_nxt_s = '0;
            case (mode_q_r)
                M_ROTATE: begin
                    pattern_nxt_s = pif.dir ? {pattern_r[0], pattern_r[WIDTH-1:1]}
                                            : {pattern_r[WIDTH-2:0], pattern_r[WIDTH-1]};
                    wrap_s        = (pattern_nxt_s == P_ONE);
                end
                M_BOUNCE: begin
                    case (bnc_st_r)
                        BNC_UP: begin
                            pattern_nxt_s = {pattern_r[WIDTH-2:0], 1'b0};
                            bnc_nxt_s     = pattern_nxt_s[WIDTH-1] ? BNC_DOWN : BNC_UP;
                        end
                        BNC_DOWN: begin
                            pattern_nxt_s = {1'b0, pattern_r[WIDTH-1:1]};
                            bnc_nxt_s     = pattern_nxt_s[0] ? BNC_UP : BNC_DOWN;
                        end
                        default: bnc_nxt_s = BNC_UP;
                    endcase
                    wrap_s = (pattern_nxt_s == P_ONE);
                end
                M_COUNTER: begin
                    pattern_nxt_s = pif.dir ? (pattern_r - P_ONE) : (pattern_r + P_ONE);
                    wrap_s        = (pattern_nxt_s == '0);
                end
                M_BAR: begin
                    case (bar_st_r)
                        BAR_FILL: begin
                            pattern_nxt_s = {pattern_r[WIDTH-2:0], 1'b1};
                            bar_nxt_s     = (pattern_nxt_s == '1) ? BAR_DRAIN : BAR_FILL;
                        end
                        BAR_DRAIN: begin
                            pattern_nxt_s = {1'b0, pattern_r[WIDTH-1:1]};
                            if (pattern_nxt_s == '0) begin
                                bar_nxt_s = BAR_FILL;
                                wrap_s    = 1'b1;
                            end else begin
                                bar_nxt_s = BAR_DRAIN;
                            end
                        end
                        default: bar_nxt_s = BAR_FILL;
                    endcase
                end
                M_LFSR: begin
                    pattern_nxt_s = {1'b0, pattern_r[WIDTH-1:1]} ^ (pattern_r[0] ? LFSR_TAPS : '0);
                    wrap_s        = (pattern_nxt_s == P_ONE);
                end
                default: pattern_nxt_s = pattern_r;
            endcase
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // LED drive: current pattern gated by mask and PWM phase, blanked in the off modes
    always_comb begin
        pwm_on_s = (pif.bright == 4'd15) || (pwm_cnt_r < pif.bright);
        if (mode_q_r >= 3'd6) begin
            led_nxt_s = '0;
        end else begin
            led_nxt_s = pattern_r & pif.mask & {WIDTH{pwm_on_s}};
        end
    end

    // State registers; strobes are delayed one cycle so they line up with the new led_out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern_r    <= '0;
            cnt_r        <= '0;
            pwm_cnt_r    <= 4'd0;
            mode_q_r     <= M_OFF;
            bnc_st_r     <= BNC_UP;
            bar_st_r     <= BAR_FILL;
            led_out_r    <= '0;
            step_d_r     <= 1'b0;
            wrap_d_r     <= 1'b0;
            step_pulse_r <= 1'b0;
            wrap_pulse_r <= 1'b0;
        end else begin
            pattern_r    <= pattern_nxt_s;
            cnt_r        <= cnt_nxt_s;
            pwm_cnt_r    <= pwm_cnt_r + 4'd1;
            mode_q_r     <= pif.mode;
            bnc_st_r     <= bnc_nxt_s;
            bar_st_r     <= bar_nxt_s;
            led_out_r    <= led_nxt_s;
            step_d_r     <= step_s;
            wrap_d_r     <= step_s && wrap_s;
            step_pulse_r <= step_d_r;
            wrap_pulse_r <= wrap_d_r;
        end
    end

    assign pif.led_out    = led_out_r;
    assign pif.step_pulse = step_pulse_r;
    assign pif.wrap_pulse = wrap_pulse_r;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed testbench for led_pattern_engine with WIDTH=8.
// Each task drives one scenario and checks the outputs against hand-computed sequences.
module tb_led_pattern_engine;
    localparam int WIDTH = 8;
    localparam int DIV_W = 24;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    led_pattern_engine_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) pif ();

    led_pattern_engine #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .pif  (pif)
    );

    always #5 clk = ~clk;

    // Waits, with a bound, for the next step strobe and returns the number of cycles waited
    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((pif.step_pulse !== 1'b1) && (cyc < 1000));
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        pif.mode = 3'd7; pif.step_div = 24'd4; pif.dir = 1'b0; pif.pause = 1'b0;
        pif.load = 1'b0; pif.seed = 8'h00; pif.mask = 8'hFF; pif.bright = 4'd15;
        repeat (3) @(negedge clk);
        checks++; if (pif.led_out !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", pif.led_out); end
        checks++; if (pif.step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", pif.step_pulse); end
        checks++; if (pif.wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", pif.wrap_pulse); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pif.led_out !== 8'h00) begin errors++; $display("FAIL reset_off_led got %h exp 00", pif.led_out); end
    endtask

    task automatic test_rotate();
        int cyc;
        logic [7:0] exp_led;
        pif.mode = 3'd0; pif.dir = 1'b0; pif.step_div = 24'd4;
        repeat (2) @(negedge clk);
        checks++; if (pif.led_out !== 8'h01) begin errors++; $display("FAIL rot_init got %h exp 01", pif.led_out); end
        checks++; if (pif.step_pulse !== 1'b0) begin errors++; $display("FAIL rot_init_step got %b exp 0", pif.step_pulse); end
        for (int k = 1; k <= 8; k++) begin
            wait_step(cyc);
            exp_led = 8'h01 << (k % 8);
            checks++; if (pif.led_out !== exp_led) begin errors++; $display("FAIL rot_led k=%0d got %h exp %h", k, pif.led_out, exp_led); end
            checks++; if (cyc != 4) begin errors++; $display("FAIL rot_period k=%0d got %0d exp 4", k, cyc); end
            checks++; if (pif.wrap_pulse !== (k == 8)) begin errors++; $display("FAIL rot_wrap k=%0d got %b exp %b", k, pif.wrap_pulse, (k == 8)); end
        end
    endtask

    task automatic test_bounce();
        int cyc;
        logic [7:0] seq [15];
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        pif.mode = 3'd1; pif.step_div = 24'd1;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 15; k++) begin
            wait_step(cyc);
            checks++; if (pif.led_out !== seq[k-1]) begin errors++; $display("FAIL bnc_led k=%0d got %h exp %h", k, pif.led_out, seq[k-1]); end
            checks++; if (cyc != 1) begin errors++; $display("FAIL bnc_period k=%0d got %0d exp 1", k, cyc); end
            checks++; if (pif.wrap_pulse !== (k == 14)) begin errors++; $display("FAIL bnc_wrap k=%0d got %b exp %b", k, pif.wrap_pulse, (k == 14)); end
        end
    endtask

    task automatic test_counter();
        int cyc, wrap_cnt, wrap_k;
        logic [7:0] exp_led;
        wrap_cnt = 0; wrap_k = 0;
        pif.mode = 3'd2; pif.dir = 1'b1; pif.step_div = 24'd1;
        @(negedge clk);
        pif.load = 1'b1; pif.seed = 8'h00;
        @(negedge clk);
        pif.load = 1'b0;
        @(negedge clk);
        checks++; if (pif.step_pulse !== 1'b0) begin errors++; $display("FAIL cnt_load_nostep got %b exp 0", pif.step_pulse); end
        checks++; if (pif.led_out !== 8'h00) begin errors++; $display("FAIL cnt_load_led got %h exp 00", pif.led_out); end
        for (int k = 1; k <= 256; k++) begin
            wait_step(cyc);
            exp_led = 8'(256 - k);
            checks++; if (pif.led_out !== exp_led) begin errors++; $display("FAIL cnt_led k=%0d got %h exp %h", k, pif.led_out, exp_led); end
            if (pif.wrap_pulse === 1'b1) begin wrap_cnt++; wrap_k = k; end
        end
        checks++; if (wrap_cnt != 1) begin errors++; $display("FAIL cnt_wrap_count got %0d exp 1", wrap_cnt); end
        checks++; if (wrap_k != 256) begin errors++; $display("FAIL cnt_wrap_step got %0d exp 256", wrap_k); end
    endtask

    task automatic test_bar();
        int cyc;
        logic [7:0] seq [17];
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F,
                8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01};
        pif.mode = 3'd3; pif.step_div = 24'd1;
        repeat (2) @(negedge clk);
        checks++; if (pif.led_out !== 8'h00) begin errors++; $display("FAIL bar_init got %h exp 00", pif.led_out); end
        for (int k = 1; k <= 17; k++) begin
            wait_step(cyc);
            checks++; if (pif.led_out !== seq[k-1]) begin errors++; $display("FAIL bar_led k=%0d got %h exp %h", k, pif.led_out, seq[k-1]); end
            checks++; if (pif.wrap_pulse !== (k == 16)) begin errors++; $display("FAIL bar_wrap k=%0d got %b exp %b", k, pif.wrap_pulse, (k == 16)); end
        end
    endtask

    task automatic test_lfsr();
        int cyc, wrap_cnt, wrap_k, zero_hits;
        logic [7:0] first [3];
        first = '{8'hB8, 8'h5C, 8'h2E};
        wrap_cnt = 0; wrap_k = 0; zero_hits = 0;
        pif.mode = 3'd4; pif.step_div = 24'd1000;
        @(negedge clk);
        pif.load = 1'b1; pif.seed = 8'h00;
        @(negedge clk);
        pif.load = 1'b0; pif.step_div = 24'd1;
        @(negedge clk);
        checks++; if (pif.led_out !== 8'h01) begin errors++; $display("FAIL lfsr_seed0 got %h exp 01", pif.led_out); end
        for (int k = 1; k <= 255; k++) begin
            wait_step(cyc);
            if (k <= 3) begin
                checks++; if (pif.led_out !== first[k-1]) begin errors++; $display("FAIL lfsr_led k=%0d got %h exp %h", k, pif.led_out, first[k-1]); end
            end
            if (pif.led_out === 8'h00) zero_hits++;
            if (pif.wrap_pulse === 1'b1) begin wrap_cnt++; wrap_k = k; end
        end
        checks++; if (pif.led_out !== 8'h01) begin errors++; $display("FAIL lfsr_period_led got %h exp 01", pif.led_out); end
        checks++; if (zero_hits != 0) begin errors++; $display("FAIL lfsr_zero got %0d exp 0", zero_hits); end
        checks++; if (wrap_cnt != 1) begin errors++; $display("FAIL lfsr_wrap_count got %0d exp 1", wrap_cnt); end
        checks++; if (wrap_k != 255) begin errors++; $display("FAIL lfsr_wrap_step got %0d exp 255", wrap_k); end
    endtask

    task automatic test_static_pwm();
        int on_cnt, bad_cnt, strobe_cnt;
        pif.mode = 3'd5; pif.seed = 8'hA5; pif.mask = 8'h0F; pif.bright = 4'd4; pif.step_div = 24'd1;
        repeat (2) @(negedge clk);
        on_cnt = 0; bad_cnt = 0; strobe_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pif.led_out === 8'h05) on_cnt++;
            else if (pif.led_out !== 8'h00) bad_cnt++;
            if (pif.wrap_pulse === 1'b1) strobe_cnt++;
        end
        checks++; if (on_cnt != 4) begin errors++; $display("FAIL pwm4_on got %0d exp 4", on_cnt); end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL pwm4_value got %0d exp 0", bad_cnt); end
        checks++; if (strobe_cnt != 0) begin errors++; $display("FAIL static_wrap got %0d exp 0", strobe_cnt); end
        pif.bright = 4'd0;
        bad_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pif.led_out !== 8'h00) bad_cnt++;
        end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL pwm0_lit got %0d exp 0", bad_cnt); end
        pif.bright = 4'd4; pif.pause = 1'b1;
        repeat (2) @(negedge clk);
        on_cnt = 0; strobe_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pif.led_out === 8'h05) on_cnt++;
            if ((pif.step_pulse === 1'b1) || (pif.wrap_pulse === 1'b1)) strobe_cnt++;
        end
        checks++; if (on_cnt != 4) begin errors++; $display("FAIL pause_pwm_on got %0d exp 4", on_cnt); end
        checks++; if (strobe_cnt != 0) begin errors++; $display("FAIL pause_strobe got %0d exp 0", strobe_cnt); end
        pif.pause = 1'b0; pif.mask = 8'hFF; pif.bright = 4'd15;
    endtask

    task automatic test_mode_load_collision();
        int cyc;
        pif.mode = 3'd0; pif.dir = 1'b0; pif.step_div = 24'd4;
        repeat (2) @(negedge clk);
        checks++; if (pif.led_out !== 8'h01) begin errors++; $display("FAIL coll_pre got %h exp 01", pif.led_out); end
        pif.mode = 3'd3; pif.load = 1'b1; pif.seed = 8'hAA;
        @(negedge clk);
        pif.load = 1'b0;
        @(negedge clk);
        checks++; if (pif.step_pulse !== 1'b0) begin errors++; $display("FAIL coll_step got %b exp 0", pif.step_pulse); end
        checks++; if (pif.led_out !== 8'h00) begin errors++; $display("FAIL coll_led got %h exp 00", pif.led_out); end
        wait_step(cyc);
        checks++; if (cyc != 4) begin errors++; $display("FAIL coll_cnt0 got %0d exp 4", cyc); end
        checks++; if (pif.led_out !== 8'h01) begin errors++; $display("FAIL coll_first got %h exp 01", pif.led_out); end
    endtask

    task automatic test_reset_mid();
        pif.mode = 3'd0; pif.step_div = 24'd1;
        repeat (3) @(negedge clk);
        checks++; if (pif.step_pulse !== 1'b1) begin errors++; $display("FAIL rmid_pre_step got %b exp 1", pif.step_pulse); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (pif.led_out !== 8'h00) begin errors++; $display("FAIL rmid_led got %h exp 00", pif.led_out); end
        checks++; if (pif.step_pulse !== 1'b0) begin errors++; $display("FAIL rmid_step got %b exp 0", pif.step_pulse); end
        checks++; if (pif.wrap_pulse !== 1'b0) begin errors++; $display("FAIL rmid_wrap got %b exp 0", pif.wrap_pulse); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pif.led_out !== 8'h01) begin errors++; $display("FAIL rmid_reload got %h exp 01", pif.led_out); end
        @(negedge clk);
        checks++; if (pif.led_out !== 8'h02) begin errors++; $display("FAIL rmid_step_led got %h exp 02", pif.led_out); end
        checks++; if (pif.step_pulse !== 1'b1) begin errors++; $display("FAIL rmid_step_pulse got %b exp 1", pif.step_pulse); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_bounce();
        test_counter();
        test_bar();
        test_lfsr();
        test_static_pwm();
        test_mode_load_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
